// File: rtl/para_deser_stream_if.sv
// Stream bundle for para_deser_stream: beat input, word output and flush request.
// master = producer/consumer side, slave = deserializer side.
interface para_deser_stream_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SHIFT_NUM  = 16
);
   logic [DATA_WIDTH-1:0]           i_data;
   logic                            i_valid;
   logic                            o_ready_in;
   logic                            i_flush;
   logic [DATA_WIDTH*SHIFT_NUM-1:0] o_data;
   logic                            o_valid;
   logic                            i_ready;
   logic [$clog2(SHIFT_NUM+1)-1:0]  o_count;

   modport master (
      output i_data, i_valid, i_flush, i_ready,
      input  o_ready_in, o_data, o_valid, o_count
   );

   modport slave (
      input  i_data, i_valid, i_flush, i_ready,
      output o_ready_in, o_data, o_valid, o_count
   );
endinterface

// File: rtl/para_deser_stream.sv
// Handshaked deserializer: SHIFT_NUM beats of DATA_WIDTH bits -> one wide word.
// Define PARA_DESER_FLUSH_EN to let i_flush emit a zero-filled partial word.
module para_deser_stream #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned SHIFT_NUM  = 16,
   parameter bit          LSB_FIRST  = 1'b1
) (
   input logic                 i_clk,
   input logic                 i_rst,
   para_deser_stream_if.slave  bus
);
   localparam int unsigned CW = $clog2(SHIFT_NUM);
   localparam int unsigned OW = $clog2(SHIFT_NUM + 1);
   localparam int unsigned WW = DATA_WIDTH * SHIFT_NUM;
   localparam logic [CW-1:0] LAST = CW'(SHIFT_NUM - 1);

   logic [WW-1:0] asm_q;
   logic [WW-1:0] merged;
   logic [CW-1:0] cnt;
   logic [CW-1:0] lane;
   logic [OW-1:0] load_count;
   logic          slot_free;
   logic          is_last;
   logic          accept;
   logic          flush_go;
   logic          load;

   assign slot_free      = !bus.o_valid || bus.i_ready;
   assign is_last        = (cnt == LAST);
   assign bus.o_ready_in = !is_last || slot_free;
   assign accept         = bus.i_valid && bus.o_ready_in;

   always_comb begin
      lane   = LSB_FIRST ? cnt : LAST - cnt;
      merged = asm_q;
      if (accept) begin
         merged[lane*DATA_WIDTH +: DATA_WIDTH] = bus.i_data;
      end
   end

`ifdef PARA_DESER_FLUSH_EN
   assign flush_go = bus.i_flush && slot_free && ((cnt != '0) || accept);
`else
   assign flush_go = 1'b0;
`endif

   // A flush landing on the final beat still loads a full word; count includes the current beat.
   assign load       = (accept && is_last) || flush_go;
   assign load_count = OW'(cnt) + OW'(accept);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         asm_q       <= '0;
         cnt         <= '0;
         bus.o_data  <= '0;
         bus.o_count <= '0;
         bus.o_valid <= 1'b0;
      end else if (load) begin
         bus.o_data  <= merged;
         bus.o_count <= load_count;
         bus.o_valid <= 1'b1;
         asm_q       <= '0;
         cnt         <= '0;
      end else begin
         if (bus.o_valid && bus.i_ready) begin
            bus.o_valid <= 1'b0;
         end
         if (accept) begin
            asm_q <= merged;
            cnt   <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_para_deser_stream.sv
// Self-checking bench: LSB-first and MSB-first instances on shared stimulus,
// compared against a beat-queue reference model.
module tb_para_deser_stream;
   localparam int unsigned DW = 8;
   localparam int unsigned SN = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] data = '0;
   logic          valid = 1'b0;
   logic          flush = 1'b0;
   logic          ready = 1'b0;

   int errors = 0;
   int checks = 0;

   para_deser_stream_if #(.DATA_WIDTH(DW), .SHIFT_NUM(SN)) bus_l ();
   para_deser_stream_if #(.DATA_WIDTH(DW), .SHIFT_NUM(SN)) bus_m ();

   assign bus_l.i_data  = data;
   assign bus_l.i_valid = valid;
   assign bus_l.i_flush = flush;
   assign bus_l.i_ready = ready;
   assign bus_m.i_data  = data;
   assign bus_m.i_valid = valid;
   assign bus_m.i_flush = flush;
   assign bus_m.i_ready = ready;

   para_deser_stream #(.DATA_WIDTH(DW), .SHIFT_NUM(SN), .LSB_FIRST(1'b1)) dut_l (
      .i_clk(clk), .i_rst(rst), .bus(bus_l)
   );
   para_deser_stream #(.DATA_WIDTH(DW), .SHIFT_NUM(SN), .LSB_FIRST(1'b0)) dut_m (
      .i_clk(clk), .i_rst(rst), .bus(bus_m)
   );

   always #5 clk = ~clk;

   // reference model: queue of accepted beats plus one output holding slot
   logic [DW-1:0]    beats[$];
   logic             m_valid = 1'b0;
   logic [DW*SN-1:0] m_word_l = '0;
   logic [DW*SN-1:0] m_word_m = '0;
   logic [2:0]       m_count = '0;
   logic             exp_ready;
   logic             obs_ready_l;
   logic             obs_ready_m;

   // advance one clock: sample ready, step the model, land on the next negedge
   task automatic cycle();
      logic sfree, acc, fl, ld;
      #1;
      sfree       = !m_valid || ready;
      exp_ready   = (beats.size() != SN - 1) || sfree;
      obs_ready_l = bus_l.o_ready_in;
      obs_ready_m = bus_m.o_ready_in;
      acc         = valid && exp_ready;
      if (acc) beats.push_back(data);
`ifdef PARA_DESER_FLUSH_EN
      fl = flush && sfree && (beats.size() > 0);
`else
      fl = 1'b0;
`endif
      ld = (acc && beats.size() == SN) || fl;
      if (rst) begin
         beats.delete();
         m_valid  = 1'b0;
         m_word_l = '0;
         m_word_m = '0;
         m_count  = '0;
      end else if (ld) begin
         m_word_l = '0;
         m_word_m = '0;
         foreach (beats[k]) begin
            m_word_l = m_word_l | ((DW*SN)'(beats[k]) << (DW * k));
            m_word_m = m_word_m | ((DW*SN)'(beats[k]) << (DW * (SN - 1 - k)));
         end
         m_count = 3'(beats.size());
         m_valid = 1'b1;
         beats.delete();
      end else if (m_valid && ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1; valid = 1'b0; flush = 1'b0; ready = 1'b0;
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 1'b1; data = 8'h5A; ready = 1'b1;
      cycle();
      checks++;
      if ({bus_l.o_valid, bus_l.o_data, bus_l.o_count} !== '0) begin
         errors++;
         $display("FAIL reset_l got v=%b d=%h c=%0d exp all zero", bus_l.o_valid, bus_l.o_data, bus_l.o_count);
      end
      checks++;
      if ({bus_m.o_valid, bus_m.o_data, bus_m.o_count} !== '0) begin
         errors++;
         $display("FAIL reset_m got v=%b d=%h c=%0d exp all zero", bus_m.o_valid, bus_m.o_data, bus_m.o_count);
      end
      rst = 1'b0; valid = 1'b0;
      #1;
      checks++;
      if (bus_l.o_ready_in !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got=%b exp=1", bus_l.o_ready_in);
      end
      @(negedge clk);
   endtask

   task automatic test_streaming();
      logic [DW-1:0] seq [4];
      seq = '{8'h11, 8'h22, 8'h33, 8'h44};
      apply_reset();
      ready = 1'b1; valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data = seq[i];
         cycle();
         checks++;
         if (obs_ready_l !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready beat%0d got=%b exp=1", i, obs_ready_l);
         end
         if (i < 3) begin
            checks++;
            if (bus_l.o_valid !== 1'b0) begin
               errors++;
               $display("FAIL stream_early_valid beat%0d got=%b exp=0", i, bus_l.o_valid);
            end
         end
      end
      valid = 1'b0;
      checks++;
      if (bus_l.o_valid !== 1'b1 || bus_l.o_data !== 32'h44332211 || bus_l.o_count !== 3'd4) begin
         errors++;
         $display("FAIL stream_word_lsb got v=%b d=%h c=%0d exp v=1 d=44332211 c=4", bus_l.o_valid, bus_l.o_data, bus_l.o_count);
      end
      checks++;
      if (bus_m.o_valid !== 1'b1 || bus_m.o_data !== 32'h11223344 || bus_m.o_count !== 3'd4) begin
         errors++;
         $display("FAIL stream_word_msb got v=%b d=%h c=%0d exp v=1 d=11223344 c=4", bus_m.o_valid, bus_m.o_data, bus_m.o_count);
      end
      cycle();
      checks++;
      if (bus_l.o_valid !== 1'b0 || bus_l.o_data !== 32'h44332211) begin
         errors++;
         $display("FAIL stream_drain got v=%b d=%h exp v=0 d=44332211", bus_l.o_valid, bus_l.o_data);
      end
   endtask

   task automatic test_back_pressure();
      apply_reset();
      ready = 1'b0; valid = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         data = 8'(i);
         cycle();
         if (i >= 4) begin
            checks++;
            if (bus_l.o_valid !== 1'b1 || bus_l.o_data !== 32'h04030201) begin
               errors++;
               $display("FAIL bp_hold beat%0d got v=%b d=%h exp v=1 d=04030201", i, bus_l.o_valid, bus_l.o_data);
            end
         end
      end
      data = 8'h08;
      for (int i = 0; i < 2; i++) begin
         cycle();
         checks++;
         if (obs_ready_l !== 1'b0 || obs_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_ready got l=%b m=%b exp 0", obs_ready_l, obs_ready_m);
         end
         checks++;
         if (bus_l.o_data !== 32'h04030201 || bus_l.o_count !== 3'd4) begin
            errors++;
            $display("FAIL bp_stable got d=%h c=%0d exp d=04030201 c=4", bus_l.o_data, bus_l.o_count);
         end
      end
      ready = 1'b1;
      cycle();
      valid = 1'b0;
      checks++;
      if (obs_ready_l !== 1'b1) begin
         errors++;
         $display("FAIL bp_release_ready got=%b exp=1", obs_ready_l);
      end
      checks++;
      if (bus_l.o_valid !== 1'b1 || bus_l.o_data !== 32'h08070605) begin
         errors++;
         $display("FAIL bp_second_word got v=%b d=%h exp v=1 d=08070605", bus_l.o_valid, bus_l.o_data);
      end
      checks++;
      if (bus_m.o_data !== 32'h05060708) begin
         errors++;
         $display("FAIL bp_second_word_msb got=%h exp=05060708", bus_m.o_data);
      end
      cycle();
   endtask

`ifdef PARA_DESER_FLUSH_EN
   task automatic test_flush();
      apply_reset();
      ready = 1'b1; valid = 1'b1;
      data = 8'hAA; cycle();
      data = 8'hBB; cycle();
      valid = 1'b0; flush = 1'b1;
      cycle();
      flush = 1'b0;
      checks++;
      if (bus_l.o_valid !== 1'b1 || bus_l.o_data !== 32'h0000BBAA || bus_l.o_count !== 3'd2) begin
         errors++;
         $display("FAIL flush_word got v=%b d=%h c=%0d exp v=1 d=0000bbaa c=2", bus_l.o_valid, bus_l.o_data, bus_l.o_count);
      end
      checks++;
      if (bus_m.o_data !== 32'hAABB0000) begin
         errors++;
         $display("FAIL flush_word_msb got=%h exp=aabb0000", bus_m.o_data);
      end
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      checks++;
      if (bus_l.o_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty_ignored got v=%b exp 0", bus_l.o_valid);
      end
      valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         data = 8'(i);
         cycle();
      end
      valid = 1'b0;
      checks++;
      if (bus_l.o_data !== 32'h04030201 || bus_l.o_count !== 3'd4) begin
         errors++;
         $display("FAIL flush_next_word got d=%h c=%0d exp d=04030201 c=4", bus_l.o_data, bus_l.o_count);
      end
      cycle();
   endtask
`endif

   task automatic test_reset_mid();
      apply_reset();
      ready = 1'b1; valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data = 8'hE0 + 8'(i);
         cycle();
      end
      rst = 1'b1; data = 8'hEE;
      cycle();
      rst = 1'b0;
      checks++;
      if ({bus_l.o_valid, bus_l.o_data, bus_l.o_count} !== '0) begin
         errors++;
         $display("FAIL midreset_zero got v=%b d=%h c=%0d exp all zero", bus_l.o_valid, bus_l.o_data, bus_l.o_count);
      end
      for (int i = 1; i <= 4; i++) begin
         data = 8'(i);
         cycle();
         if (i < 4) begin
            checks++;
            if (bus_l.o_valid !== 1'b0) begin
               errors++;
               $display("FAIL midreset_early_valid beat%0d got=%b exp=0", i, bus_l.o_valid);
            end
         end
      end
      valid = 1'b0;
      checks++;
      if (bus_l.o_valid !== 1'b1 || bus_l.o_data !== 32'h04030201) begin
         errors++;
         $display("FAIL midreset_word got v=%b d=%h exp v=1 d=04030201", bus_l.o_valid, bus_l.o_data);
      end
      cycle();
   endtask

   task automatic test_random();
      apply_reset();
      valid = 1'b0;
      for (int n = 0; n < 400; n++) begin
         // hold an offered beat until it is taken
         if (!(valid && !exp_ready) || n == 0) begin
            valid = ($urandom_range(0, 3) != 0);
            data  = 8'($urandom);
         end
         ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 7) == 0);
         cycle();
         checks++;
         if (obs_ready_l !== exp_ready || obs_ready_m !== exp_ready) begin
            errors++;
            $display("FAIL rand_ready n=%0d got l=%b m=%b exp=%b", n, obs_ready_l, obs_ready_m, exp_ready);
         end
         checks++;
         if (bus_l.o_valid !== m_valid || bus_m.o_valid !== m_valid) begin
            errors++;
            $display("FAIL rand_valid n=%0d got l=%b m=%b exp=%b", n, bus_l.o_valid, bus_m.o_valid, m_valid);
         end
         checks++;
         if (bus_l.o_data !== m_word_l || bus_m.o_data !== m_word_m) begin
            errors++;
            $display("FAIL rand_data n=%0d got l=%h m=%h exp l=%h m=%h", n, bus_l.o_data, bus_m.o_data, m_word_l, m_word_m);
         end
         checks++;
         if (bus_l.o_count !== m_count || bus_m.o_count !== m_count) begin
            errors++;
            $display("FAIL rand_count n=%0d got l=%0d m=%0d exp=%0d", n, bus_l.o_count, bus_m.o_count, m_count);
         end
      end
      valid = 1'b0; flush = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_streaming();
      test_back_pressure();
`ifdef PARA_DESER_FLUSH_EN
      test_flush();
`endif
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
